tmr_multi: RTL and testbench
============================

// Module: tmr_multi
// PURPOSE
//   Parametrised multi-channel programmable timer; successor of the single-channel tmr.
//   NUM_CH independent down-counters share one prescaler tick. Each channel adds run
//   and one-shot controls and a readable live count. Sits on the I/O bus like tmr.
//   irq = OR over channels of (ien & alarm).
// PARAMETERS
//   NUM_CH    2   number of timer channels (1..16)
//   CNT_W     32  counter/divisor width (1..32); bus reads zero-extend to 32 bits
//   PRESCALE  50  clk cycles per tick (>=2); 50 gives 1 us at 50 MHz
//   localparam AW = $clog2(NUM_CH)+2; addr = {channel, reg[1:0]}
// PORTS
//   clk       in   1   clock
//   reset     in   1   synchronous, active-high reset
//   en        in   1   bus cycle select
//   wr        in   1   1 = write, 0 = read
//   addr      in   AW  {ch, reg}; reg 0=CTRL, 1=DIVISOR, 2=COUNT (RO), 3=reserved
//   data_in   in   32  write data
//   data_out  out  32  read data, combinational from addr
//   wt        out  1   wait; tied 0 (single-cycle access)
//   irq       out  1   OR of (ien & alarm) over all channels
// BEHAVIOUR
//   - Reset: prescaler=PRESCALE, tick=0; per channel divisor=counter=all-ones, alarm=0,
//     ien=0, run=1, oneshot=0 (channel 0 runs exactly like legacy tmr). irq=0.
//   - Prescaler counts PRESCALE..1; on reaching 1 it reloads and tick pulses for 1 cycle.
//   - CTRL bits: [0] alarm (R/W, write 0 to ack), [1] ien, [2] run, [3] oneshot;
//     [31:4] read 0.
//   - DIVISOR write: divisor<=data_in[CNT_W-1:0]; counter<=same value next cycle;
//     suppresses any expiry in that cycle.
//   - Count: on tick with run=1: counter==1 -> counter<=divisor, expire;
//     else counter<=counter-1. run=0 freezes counter.
//   - Divisor 0: decrement wraps 0 -> all-ones; period 2^CNT_W ticks.
//   - Expire: alarm<=1 on the next edge (alarm visible 1 cycle after the tick cycle with
//     counter==1). oneshot=1 also clears run on the same edge (counter holds divisor).
//   - CTRL write in the same cycle as expire: alarm ends 1 (expire wins); ien/run/oneshot
//     take the written values.
//   - Reads: CTRL/DIVISOR/COUNT of addressed channel; reg 3 or ch>=NUM_CH reads 0, and
//     writes there are ignored.
//   - COUNT writes are ignored.
//   - Reset mid-count: all state returns to reset values on that edge; no pending alarm
//     survives.
// CONFIGURATION
//   TMR_MULTI_IRQVEC_EN defined: adds output irq_vec[NUM_CH-1:0], bit c = ien_c & alarm_c,
//     registered-free (same timing as irq); irq still present.
//   Undefined: port absent; only the ORed irq exists.
// STRUCTURE
//   tmr_multi_pkg: REG_CTRL/REG_DIV/REG_COUNT offsets, CTRL bit indices
//     (CTRL_ALARM=0, CTRL_IEN=1, CTRL_RUN=2, CTRL_ONESHOT=3).
//   Sub-module tmr_multi_chan (CNT_W): counter, divisor, ctrl regs, expire logic;
//     instantiated NUM_CH times by generate. Prescaler and bus decode live in the top.
// TESTING
//   1 Reset, NUM_CH=2, PRESCALE=4; write ch0 DIVISOR=3, CTRL=0x6 -> irq rises 12 clk
//     (+1) later, repeats every 12 clk.
//   2 ch1 CTRL=0xE (oneshot), DIVISOR=2 -> one alarm after 2 ticks; CTRL reads 0xB,
//     COUNT holds 2.
//   3 Ack: write CTRL=0x6 on the exact expire cycle -> alarm stays 1, irq stays high.
//   4 run=0 mid-count at COUNT=5 -> COUNT stays 5 over 10 ticks; run=1 resumes 5->4.
//   5 Read addr reg 3 and ch>=NUM_CH -> 0; write there -> no channel state changes.
//   6 Assert reset while ch0 alarm=1 -> irq=0, CTRL=0x4, DIVISOR=0xFFFFFFFF next cycle.

Source files
------------

// File: rtl/tmr_multi_pkg.sv
// tmr_multi_pkg
//   Shared definitions for the multi-channel timer: register offsets within a
//   channel's four-word window and bit positions inside the CTRL register.
package tmr_multi_pkg;

    // Register offset inside a channel window: addr = {channel, reg[1:0]}
    typedef enum logic [1:0] {
        REG_CTRL  = 2'd0,
        REG_DIV   = 2'd1,
        REG_COUNT = 2'd2,
        REG_RSVD  = 2'd3
    } reg_e;

    // CTRL register bit positions
    localparam int unsigned CTRL_ALARM   = 0;
    localparam int unsigned CTRL_IEN     = 1;
    localparam int unsigned CTRL_RUN     = 2;
    localparam int unsigned CTRL_ONESHOT = 3;
    localparam int unsigned CTRL_W       = 4;

endpackage

// File: rtl/tmr_multi_chan.sv
// tmr_multi_chan
//   One timer channel: divisor, live down-counter, CTRL flags and expire logic.
//   The counter advances only on shared prescaler ticks while run is set.
// Ports
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   tick_i     in   one-cycle prescaler tick
//   ctrl_we_i  in   write strobe for CTRL
//   div_we_i   in   write strobe for DIVISOR (also reloads the counter)
//   wdata_i    in   bus write data
//   ctrl_o     out  {oneshot, run, ien, alarm}
//   div_o      out  divisor value
//   cnt_o      out  live counter value
//   irq_o      out  ien & alarm
module tmr_multi_chan
    import tmr_multi_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_i,
    input  logic              ctrl_we_i,
    input  logic              div_we_i,
    input  logic [31:0]       wdata_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [CNT_W-1:0]  div_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              irq_o
);

    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             alarm_q, alarm_d;
    logic             ien_q, ien_d;
    logic             run_q, run_d;
    logic             oneshot_q, oneshot_d;
    logic             advance;
    logic             expire;

    // A DIVISOR write takes priority over counting and masks any expiry.
    assign advance = tick_i & run_q & ~div_we_i;
    assign expire  = advance & (cnt_q == CNT_W'(1));

    always_comb begin
        div_d     = div_q;
        cnt_d     = cnt_q;
        alarm_d   = alarm_q;
        ien_d     = ien_q;
        run_d     = run_q;
        oneshot_d = oneshot_q;

        if (div_we_i) begin
            div_d = wdata_i[CNT_W-1:0];
            cnt_d = wdata_i[CNT_W-1:0];
        end else if (advance) begin
            // Divisor 0 simply wraps through all-ones, giving a 2^CNT_W period.
            cnt_d = expire ? div_q : cnt_q - CNT_W'(1);
        end

        if (ctrl_we_i) begin
            alarm_d   = wdata_i[CTRL_ALARM];
            ien_d     = wdata_i[CTRL_IEN];
            run_d     = wdata_i[CTRL_RUN];
            oneshot_d = wdata_i[CTRL_ONESHOT];
        end

        // Expiry beats a simultaneous ack; a simultaneous CTRL write keeps its run value.
        if (expire) begin
            alarm_d = 1'b1;
            if (oneshot_q && !ctrl_we_i) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q     <= '1;
            cnt_q     <= '1;
            alarm_q   <= 1'b0;
            ien_q     <= 1'b0;
            run_q     <= 1'b1;
            oneshot_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            alarm_q   <= alarm_d;
            ien_q     <= ien_d;
            run_q     <= run_d;
            oneshot_q <= oneshot_d;
        end
    end

    assign ctrl_o = {oneshot_q, run_q, ien_q, alarm_q};
    assign div_o  = div_q;
    assign cnt_o  = cnt_q;
    assign irq_o  = ien_q & alarm_q;

endmodule

// File: rtl/tmr_multi.sv
// tmr_multi
//   Multi-channel programmable timer on the I/O bus. NUM_CH independent
//   down-counters share one prescaler tick (one tick every PRESCALE clocks).
//   Optional feature: define TMR_MULTI_IRQVEC_EN to expose the per-channel
//   interrupt vector irq_vec alongside the ORed irq.
// Ports
//   clk       in   clock
//   reset     in   synchronous, active-high reset
//   en        in   bus cycle select
//   wr        in   1 = write, 0 = read
//   addr      in   {channel, reg[1:0]}; reg 0=CTRL 1=DIVISOR 2=COUNT(RO) 3=reserved
//   data_in   in   write data
//   data_out  out  read data, combinational from addr
//   wt        out  wait, always 0
//   irq       out  OR over channels of (ien & alarm)
//   irq_vec   out  per-channel ien & alarm (TMR_MULTI_IRQVEC_EN only)
module tmr_multi
    import tmr_multi_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned PRESCALE = 50,
    localparam int unsigned AW      = $clog2(NUM_CH) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              wr,
    input  logic [AW-1:0]     addr,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              wt,
    output logic              irq
`ifdef TMR_MULTI_IRQVEC_EN
    ,
    output logic [NUM_CH-1:0] irq_vec
`endif
);

    localparam int unsigned PW = $clog2(PRESCALE + 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic              tick_q, tick_d;
    logic [AW-1:0]     ch_idx;
    reg_e              reg_sel;
    logic [CTRL_W-1:0] ctrl_w [NUM_CH];
    logic [CNT_W-1:0]  div_w  [NUM_CH];
    logic [CNT_W-1:0]  cnt_w  [NUM_CH];
    logic [NUM_CH-1:0] irq_ch;

    // Prescaler counts PRESCALE..1 and pulses tick for one cycle on reload.
    always_comb begin
        presc_d = presc_q - PW'(1);
        tick_d  = 1'b0;
        if (presc_q == PW'(1)) begin
            presc_d = PW'(PRESCALE);
            tick_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= PW'(PRESCALE);
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign ch_idx  = addr >> 2;
    assign reg_sel = reg_e'(addr[1:0]);

    // Channels that do not exist never match ch_idx, so writes there are dropped.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic sel;
        assign sel = en & wr & (ch_idx == AW'(c));

        tmr_multi_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .tick_i    (tick_q),
            .ctrl_we_i (sel && (reg_sel == REG_CTRL)),
            .div_we_i  (sel && (reg_sel == REG_DIV)),
            .wdata_i   (data_in),
            .ctrl_o    (ctrl_w[c]),
            .div_o     (div_w[c]),
            .cnt_o     (cnt_w[c]),
            .irq_o     (irq_ch[c])
        );
    end

    always_comb begin
        data_out = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_idx == AW'(c)) begin
                case (reg_sel)
                    REG_CTRL:  data_out = 32'(ctrl_w[c]);
                    REG_DIV:   data_out = 32'(div_w[c]);
                    REG_COUNT: data_out = 32'(cnt_w[c]);
                    default:   data_out = '0;
                endcase
            end
        end
    end

    assign wt  = 1'b0;
    assign irq = |irq_ch;

`ifdef TMR_MULTI_IRQVEC_EN
    assign irq_vec = irq_ch;
`endif

endmodule

// File: tb/tb_tmr_multi.sv
// tb_tmr_multi
//   Bench for tmr_multi with NUM_CH=3 (so channel index 3 is out of range),
//   CNT_W=32, PRESCALE=4. A behavioural model tracks per-channel state from the
//   edge count since reset; directed scenarios plus a randomized bus run.
module tb_tmr_multi;

    localparam int unsigned NCH = 3;
    localparam int unsigned PRE = 4;
    localparam int unsigned AW  = $clog2(NCH) + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   data_in = '0;
    logic [31:0]   data_out;
    logic          wt;
    logic          irq;
`ifdef TMR_MULTI_IRQVEC_EN
    logic [NCH-1:0] irq_vec;
`endif

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;

    tmr_multi #(
        .NUM_CH   (NCH),
        .CNT_W    (32),
        .PRESCALE (PRE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .wt       (wt),
        .irq      (irq)
`ifdef TMR_MULTI_IRQVEC_EN
        ,
        .irq_vec  (irq_vec)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int unsigned m_edges;
    logic [31:0] m_div   [NCH];
    logic [31:0] m_cnt   [NCH];
    bit          m_alarm [NCH];
    bit          m_ien   [NCH];
    bit          m_run   [NCH];
    bit          m_os    [NCH];

    // The tick that lets counters move at edge n was produced at edge n-1;
    // after reset the prescaler first reloads on edge PRE, so counting edges
    // are PRE+1, 2*PRE+1, ...
    function automatic bit tick_at(int unsigned n);
        return (n > 1) && (n % PRE == 1);
    endfunction

    function automatic void model_edge(bit r, bit e, bit w, logic [AW-1:0] a, logic [31:0] d);
        int unsigned ch;
        int unsigned rg;
        bit tick;
        ch = int'(a) >> 2;
        rg = int'(a) & 3;
        if (r) begin
            m_edges = 0;
            for (int c = 0; c < NCH; c++) begin
                m_div[c] = 32'hFFFF_FFFF; m_cnt[c] = 32'hFFFF_FFFF;
                m_alarm[c] = 0; m_ien[c] = 0; m_run[c] = 1; m_os[c] = 0;
            end
            return;
        end
        m_edges++;
        tick = tick_at(m_edges);
        for (int c = 0; c < NCH; c++) begin
            bit wdiv, wctl, ex, os_old;
            wdiv   = e && w && (ch == c) && (rg == 1);
            wctl   = e && w && (ch == c) && (rg == 0);
            ex     = tick && m_run[c] && !wdiv && (m_cnt[c] == 1);
            os_old = m_os[c];
            if (wdiv) begin
                m_div[c] = d; m_cnt[c] = d;
            end else if (tick && m_run[c]) begin
                m_cnt[c] = ex ? m_div[c] : m_cnt[c] - 1;
            end
            if (wctl) begin
                m_alarm[c] = d[0]; m_ien[c] = d[1]; m_run[c] = d[2]; m_os[c] = d[3];
            end
            if (ex) begin
                m_alarm[c] = 1;
                if (os_old && !wctl) m_run[c] = 0;
            end
        end
    endfunction

    function automatic logic [31:0] m_read(logic [AW-1:0] a);
        int unsigned ch;
        int unsigned rg;
        ch = int'(a) >> 2;
        rg = int'(a) & 3;
        if (ch >= NCH) return 32'h0;
        case (rg)
            0: return {28'h0, m_os[ch], m_run[ch], m_ien[ch], m_alarm[ch]};
            1: return m_div[ch];
            2: return m_cnt[ch];
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_irq();
        bit v = 0;
        for (int c = 0; c < NCH; c++) v |= m_ien[c] & m_alarm[c];
        return v;
    endfunction

    function automatic bit will_expire(int unsigned c);
        return tick_at(m_edges + 1) && m_run[c] && (m_cnt[c] == 1);
    endfunction

    // Drive one bus cycle, advance the model over the edge, settle past the edge.
    task automatic step(input bit r, input bit e, input bit w, input logic [AW-1:0] a,
                        input logic [31:0] d);
        reset = r; en = e; wr = w; addr = a; data_in = d;
        @(posedge clk);
        model_edge(r, e, w, a, d);
        cyc++;
        #1;
    endtask

    function automatic logic [AW-1:0] A(int unsigned ch, int unsigned rg);
        return AW'((ch << 2) | rg);
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        step(1, 0, 0, A(0, 0), 0);
        step(1, 0, 0, A(0, 0), 0);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++; $display("FAIL reset_irq: got %b want 0", irq);
        end
        vectors++;
        if (wt !== 1'b0) begin
            miscompares++; $display("FAIL reset_wt: got %b want 0", wt);
        end
        vectors++;
        if (data_out !== 32'h4) begin
            miscompares++; $display("FAIL reset_ctrl0: got %h want 00000004", data_out);
        end
        step(0, 1, 0, A(1, 1), 0);
        vectors++;
        if (data_out !== 32'hFFFF_FFFF) begin
            miscompares++; $display("FAIL reset_div1: got %h want ffffffff", data_out);
        end
        step(0, 1, 0, A(1, 2), 0);
        vectors++;
        if (data_out !== m_read(A(1, 2))) begin
            miscompares++; $display("FAIL reset_cnt1: got %h want %h", data_out, m_read(A(1, 2)));
        end
    endtask

    task automatic test_periodic();
        int unsigned t1, t2;
        bit seen;
        step(0, 1, 1, A(0, 1), 32'd3);
        step(0, 1, 1, A(0, 0), 32'h6);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(0, 1, 0, A(0, 2), 0);
            vectors++;
            if (irq !== m_irq() || data_out !== m_read(A(0, 2))) begin
                miscompares++;
                $display("FAIL periodic_first: irq %b cnt %h want irq %b cnt %h",
                         irq, data_out, m_irq(), m_read(A(0, 2)));
            end
            if (irq === 1'b1) seen = 1;
        end
        vectors++;
        if (!seen) begin
            miscompares++; $display("FAIL periodic_rise: irq stayed 0, want 1 within 40 clk");
        end
        t1 = cyc;
        step(0, 1, 1, A(0, 0), 32'h6);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(0, 1, 0, A(0, 0), 0);
            if (irq === 1'b1) seen = 1;
        end
        t2 = cyc;
        vectors++;
        if (!seen || (t2 - t1) != 3 * PRE) begin
            miscompares++; $display("FAIL periodic_period: got %0d clk want %0d", t2 - t1, 3 * PRE);
        end
    endtask

    task automatic test_oneshot();
        step(0, 1, 1, A(1, 0), 32'hE);
        step(0, 1, 1, A(1, 1), 32'd2);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, A(1, 0), 0);
            vectors++;
            if (data_out !== m_read(A(1, 0))) begin
                miscompares++; $display("FAIL oneshot_ctrl_trace: got %h want %h", data_out, m_read(A(1, 0)));
            end
        end
        vectors++;
        if (data_out !== 32'hB) begin
            miscompares++; $display("FAIL oneshot_ctrl: got %h want 0000000b", data_out);
        end
        step(0, 1, 0, A(1, 2), 0);
        vectors++;
        if (data_out !== 32'd2) begin
            miscompares++; $display("FAIL oneshot_count: got %h want 00000002", data_out);
        end
        step(0, 1, 1, A(1, 0), 32'h8);
        repeat (20) step(0, 0, 0, A(1, 0), 0);
        vectors++;
        if (data_out !== 32'h8) begin
            miscompares++; $display("FAIL oneshot_single: got %h want 00000008", data_out);
        end
    endtask

    task automatic test_ack_on_expire();
        bit found;
        step(0, 1, 1, A(1, 0), 32'h0);
        step(0, 1, 1, A(0, 0), 32'h6);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (will_expire(0)) found = 1;
            else step(0, 1, 0, A(0, 0), 0);
        end
        vectors++;
        if (!found) begin
            miscompares++; $display("FAIL ack_find: no expire within 30 clk, want one");
        end
        step(0, 1, 1, A(0, 0), 32'h6);
        vectors++;
        if (data_out !== 32'h7 || data_out !== m_read(A(0, 0))) begin
            miscompares++; $display("FAIL ack_expire_ctrl: got %h want 00000007", data_out);
        end
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++; $display("FAIL ack_expire_irq: got %b want 1", irq);
        end
    endtask

    task automatic test_run_freeze();
        bit found;
        step(0, 1, 1, A(0, 1), 32'd8);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            step(0, 1, 0, A(0, 2), 0);
            if (m_cnt[0] == 5) found = 1;
        end
        vectors++;
        if (!found || data_out !== 32'd5) begin
            miscompares++; $display("FAIL freeze_reach5: got %h want 00000005", data_out);
        end
        step(0, 1, 1, A(0, 0), 32'h2);
        for (int i = 0; i < 10 * PRE; i++) begin
            step(0, 1, 0, A(0, 2), 0);
            vectors++;
            if (data_out !== 32'd5) begin
                miscompares++; $display("FAIL freeze_hold: got %h want 00000005", data_out);
            end
        end
        step(0, 1, 1, A(0, 0), 32'h6);
        found = 0;
        for (int i = 0; i < 2 * PRE && !found; i++) begin
            step(0, 1, 0, A(0, 2), 0);
            if (m_cnt[0] != 5) found = 1;
        end
        vectors++;
        if (!found || data_out !== 32'd4) begin
            miscompares++; $display("FAIL freeze_resume: got %h want 00000004", data_out);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] snap [NCH][3];
        for (int c = 0; c < NCH; c++) step(0, 1, 1, A(c, 0), 32'h0);
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < 3; r++) snap[c][r] = m_read(A(c, r));
        for (int a = 0; a < (1 << AW); a++) begin
            if ((a & 3) == 3 || (a >> 2) >= NCH) begin
                step(0, 1, 0, AW'(a), 0);
                vectors++;
                if (data_out !== 32'h0) begin
                    miscompares++; $display("FAIL unmapped_read a=%0d: got %h want 0", a, data_out);
                end
                step(0, 1, 1, AW'(a), 32'hFFFF_FFFF);
            end
        end
        step(0, 1, 1, A(0, 2), 32'h123);
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < 3; r++) begin
                step(0, 1, 0, A(c, r), 0);
                vectors++;
                if (data_out !== snap[c][r]) begin
                    miscompares++;
                    $display("FAIL unmapped_state ch%0d reg%0d: got %h want %h", c, r, data_out, snap[c][r]);
                end
            end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 1, A(0, 0), 32'h3);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_pre_irq: got %b want 1", irq);
        end
        step(1, 1, 0, A(0, 0), 0);
        vectors++;
        if (irq !== 1'b0 || data_out !== 32'h4) begin
            miscompares++; $display("FAIL rstmid_ctrl: irq %b ctrl %h want irq 0 ctrl 00000004", irq, data_out);
        end
        step(0, 1, 0, A(0, 1), 0);
        vectors++;
        if (data_out !== 32'hFFFF_FFFF) begin
            miscompares++; $display("FAIL rstmid_div: got %h want ffffffff", data_out);
        end
    endtask

    task automatic test_random();
        bit r, e, w;
        logic [AW-1:0] a;
        logic [31:0] d;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 2) == 0);
            w = $urandom_range(0, 1);
            a = AW'($urandom_range(0, (1 << AW) - 1));
            case (int'(a) & 3)
                0: d = {$urandom, 4'(($urandom_range(0, 15)) | 4)} >> 0;
                1: d = $urandom_range(0, 5);
                default: d = $urandom;
            endcase
            if ((int'(a) & 3) == 0) d = {28'($urandom), 4'($urandom_range(0, 15))};
            step(r, e, w, a, d);
            vectors++;
            if (irq !== m_irq() || data_out !== m_read(a)) begin
                miscompares++;
                $display("FAIL random i=%0d a=%0d: irq %b data %h want irq %b data %h",
                         i, a, irq, data_out, m_irq(), m_read(a));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_ack_on_expire();
        test_run_freeze();
        test_unmapped();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
